exc_halt_ctrl: RTL and testbench
================================

// Module: exc_halt_ctrl
// PURPOSE
//  Sequential consumer of the opcode/overflow exception check. Sits between decode/ALU and PC/pipeline control.
//  On a faulting instruction it latches the cause and faulting PC, flushes the pipeline for a fixed drain period,
//  then parks the core halted until the debug host resumes it. It also keeps a saturating exception count.
// PARAMETERS
//  PC_W          16  width of pc / epc
//  FLUSH_CYCLES   2  cycles flush is held high; legal range >=1
//  CNT_W          8  width of exc_count
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  instr_valid  in   1      opcode/pc/overflow describe a real instruction this cycle
//  opcode       in   4      instruction opcode
//  pc           in   PC_W   address of that instruction
//  overflow     in   1      ALU signed overflow for that instruction
//  resume_req   in   1      host request to leave HALTED (level)
//  stall        out  1      freeze PC and pipeline registers
//  flush        out  1      squash in-flight instructions
//  halted       out  1      core parked, waiting on resume
//  cause        out  2      00 none, 01 illegal opcode, 10 overflow, 11 both
//  epc          out  PC_W   pc of the faulting instruction
//  resume_ack   out  1      one-cycle pulse on leaving HALTED
//  exc_count    out  CNT_W  exceptions taken, saturating
// BEHAVIOUR
//  - Legal opcodes: 0x0,0x4,0x5,0x6,0x8,0xB,0xC,0xF. illegal = instr_valid & opcode not in set;
//    ovf = instr_valid & overflow. Exception fires when illegal|ovf; the cause bits are set independently (no override).
//  - All outputs are registered. Reset (async, rst_n=0) gives state RUN and drives 0 on every output,
//    including epc and exc_count. A reset mid-FLUSH or mid-HALTED abandons the operation immediately.
//  - FSM states: RUN, FLUSH, HALTED, RESUME.
//    RUN: on exception at edge N, latch cause/epc, exc_count+=1 (hold at all-ones), enter FLUSH.
//      stall=1 and flush=1 are visible from cycle N+1. With no exception, stall=flush=0.
//    FLUSH: flush=1 and stall=1 for exactly FLUSH_CYCLES cycles (down-counter loaded with FLUSH_CYCLES-1),
//      then go to HALTED. New exceptions and resume_req are ignored here; cause and epc stay frozen.
//    HALTED: halted=1, stall=1, flush=0. Further exceptions are ignored. Sampling resume_req=1 enters RESUME.
//    RESUME: a single cycle with resume_ack=1, stall=1 and halted=0. cause is cleared to 00;
//      epc keeps its last value. Then go to RUN, where stall drops.
//  - Exception latency: detection edge to first flush cycle is 1 clk. Detection edge to halted is FLUSH_CYCLES+1 clk.
//  - resume_req held high across RESUME does not re-trigger anything. It is only honoured in HALTED.
//  - An instruction with instr_valid=0 never raises an exception, whatever its opcode or overflow.
//  - An exception presented in RUN in the same cycle as resume_req is taken; resume_req is ignored.
// STRUCTURE
//  - Shared package cpu_pkg holds: the OPC_* opcode constants, the 2-bit CAUSE_* encodings, and the exc_state_t enum.
//  - One sub-module, opc_legal_chk: a combinational 4-bit legality decode, reusable by the decoder.
//  - The counter, FSM and capture registers stay in this module.
// TESTING
//  1. Reset, then opcode 0x4 valid with no overflow for 10 clk: stall=flush=halted=0, cause=00, exc_count=0.
//  2. Illegal opcode: opcode=0x2, pc=0x0040, valid at edge N -> flush high N+1..N+2, halted from N+3,
//     cause=01, epc=0x0040, exc_count=1.
//  3. Both causes at once: opcode=0x9 with overflow=1, pc=0x1234 -> cause=11, epc=0x1234.
//     A second fault (opcode 0x3) during FLUSH leaves epc=0x1234 and exc_count=1.
//  4. Resume: in HALTED, raise resume_req for 3 clk -> resume_ack pulses exactly once, cause goes to 00,
//     stall low one clk after ack, epc still 0x1234.
//  5. Reset mid-flush: assert rst_n=0 asynchronously during FLUSH -> all outputs read 0 before the next edge;
//     after release the FSM is in RUN.
//  6. Masking and saturation: opcode=0xE with instr_valid=0 -> no exception. With CNT_W=2, take 5 exceptions
//     (each resumed) -> exc_count stays at 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, exception cause encodings and exception FSM states
package cpu_pkg;
   localparam logic [3:0] OPC_NOP  = 4'h0;
   localparam logic [3:0] OPC_ADD  = 4'h4;
   localparam logic [3:0] OPC_SUB  = 4'h5;
   localparam logic [3:0] OPC_AND  = 4'h6;
   localparam logic [3:0] OPC_LD   = 4'h8;
   localparam logic [3:0] OPC_ST   = 4'hB;
   localparam logic [3:0] OPC_BR   = 4'hC;
   localparam logic [3:0] OPC_HALT = 4'hF;
   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_ILL  = 2'b01;
   localparam logic [1:0] CAUSE_OVF  = 2'b10;
   localparam logic [1:0] CAUSE_BOTH = 2'b11;
   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_HALTED, ST_RESUME} exc_state_t;
endpackage

// File: rtl/exc_halt_ctrl_if.sv
// exc_halt_ctrl_if: instruction/exception-check inputs and pipeline-control outputs of the halt controller
interface exc_halt_ctrl_if #(parameter int PC_W = 16, parameter int CNT_W = 8);
   logic             instr_valid;
   logic [3:0]       opcode;
   logic [PC_W-1:0]  pc;
   logic             overflow;
   logic             resume_req;
   logic             stall;
   logic             flush;
   logic             halted;
   logic [1:0]       cause;
   logic [PC_W-1:0]  epc;
   logic             resume_ack;
   logic [CNT_W-1:0] exc_count;
   modport master (output instr_valid, opcode, pc, overflow, resume_req,
                   input stall, flush, halted, cause, epc, resume_ack, exc_count);
   modport slave  (input instr_valid, opcode, pc, overflow, resume_req,
                   output stall, flush, halted, cause, epc, resume_ack, exc_count);
endinterface

// File: rtl/exc_halt_ctrl_opc_legal_chk.sv
// opc_legal_chk: combinational decode of whether a 4-bit opcode is implemented
module opc_legal_chk
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       legal
);
   assign legal = opcode inside {OPC_NOP, OPC_ADD, OPC_SUB, OPC_AND, OPC_LD, OPC_ST, OPC_BR, OPC_HALT};
endmodule

// File: rtl/exc_halt_ctrl.sv
// exc_halt_ctrl: latches faulting cause/pc, drains the pipeline, halts until resumed, counts exceptions
module exc_halt_ctrl
   import cpu_pkg::*;
#(
   parameter int PC_W         = 16,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 8
) (
   input logic            clk,
   input logic            rst_n,
   exc_halt_ctrl_if.slave bus
);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);
   exc_state_t state, nxt;
   logic [FW-1:0] fcnt, fcnt_nxt;
   logic legal, ill, ofl, exc;
   opc_legal_chk u_chk (.opcode(bus.opcode), .legal(legal));
   assign ill = bus.instr_valid & ~legal;
   assign ofl = bus.instr_valid & bus.overflow;
   assign exc = ill | ofl;
   // next state: exceptions only honoured in RUN, resume only in HALTED
   always_comb begin
      nxt = state;
      fcnt_nxt = fcnt;
      case (state)
         ST_RUN: begin
            nxt = exc ? ST_FLUSH : ST_RUN;
            fcnt_nxt = FW'(FLUSH_CYCLES - 1);
         end
         ST_FLUSH: begin
            nxt = (fcnt == '0) ? ST_HALTED : ST_FLUSH;
            fcnt_nxt = (fcnt == '0) ? fcnt : fcnt - 1'b1;
         end
         ST_HALTED: nxt = bus.resume_req ? ST_RESUME : ST_HALTED;
         default:   nxt = ST_RUN;
      endcase
   end
   // state, capture registers and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_RUN;
         fcnt           <= '0;
         bus.stall      <= 1'b0;
         bus.flush      <= 1'b0;
         bus.halted     <= 1'b0;
         bus.resume_ack <= 1'b0;
         bus.cause      <= CAUSE_NONE;
         bus.epc        <= '0;
         bus.exc_count  <= '0;
      end else begin
         state          <= nxt;
         fcnt           <= fcnt_nxt;
         bus.stall      <= nxt != ST_RUN;
         bus.flush      <= nxt == ST_FLUSH;
         bus.halted     <= nxt == ST_HALTED;
         bus.resume_ack <= nxt == ST_RESUME;
         if (state == ST_RUN && exc) begin
            bus.cause     <= {ofl, ill};
            bus.epc       <= bus.pc;
            bus.exc_count <= (&bus.exc_count) ? bus.exc_count : bus.exc_count + CNT_W'(1);
         end
         if (state == ST_HALTED && bus.resume_req)
            bus.cause <= CAUSE_NONE;
      end
   end
endmodule

// File: tb/tb_exc_halt_ctrl.sv
// tb_exc_halt_ctrl: directed scoreboard bench for exc_halt_ctrl (8-bit and 2-bit counter instances)
module tb_exc_halt_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   exc_halt_ctrl_if #(.PC_W(16), .CNT_W(8)) i1 ();
   exc_halt_ctrl_if #(.PC_W(16), .CNT_W(2)) i2 ();
   assign i2.instr_valid = i1.instr_valid;
   assign i2.opcode      = i1.opcode;
   assign i2.pc          = i1.pc;
   assign i2.overflow    = i1.overflow;
   assign i2.resume_req  = i1.resume_req;
   exc_halt_ctrl #(.PC_W(16), .FLUSH_CYCLES(2), .CNT_W(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(i1));
   exc_halt_ctrl #(.PC_W(16), .FLUSH_CYCLES(2), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(i2));

   typedef struct {string tag; logic [31:0] v;} exp_t;
   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   int ms, mf, acks;
   logic [1:0] mc, mn2;
   logic [15:0] me;
   logic [7:0] mn;

   function automatic logic [31:0] obs();
      return {i1.stall, i1.flush, i1.halted, i1.cause, i1.epc, i1.resume_ack, i1.exc_count, i2.exc_count};
   endfunction

   function automatic logic [31:0] model_out();
      return {ms != 0, ms == 1, ms == 2, mc, me, ms == 3, mn, mn2};
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      ms = 0; mf = 0; mc = 2'b00; me = '0; mn = '0; mn2 = '0;
      sb.delete();
   endtask

   task automatic model_step(input logic v, input logic [3:0] op, input logic [15:0] p, input logic ov, input logic rr);
      logic ill, ofl;
      ill = v && !(op inside {4'h0, 4'h4, 4'h5, 4'h6, 4'h8, 4'hB, 4'hC, 4'hF});
      ofl = v && ov;
      case (ms)
         0: if (ill || ofl) begin
               ms = 1; mf = 1; mc = {ofl, ill}; me = p;
               mn = (mn == 8'hFF) ? mn : mn + 8'd1;
               mn2 = (mn2 == 2'b11) ? mn2 : mn2 + 2'd1;
            end
         1: if (mf == 0) ms = 2; else mf--;
         2: if (rr) begin ms = 3; mc = 2'b00; end
         default: ms = 0;
      endcase
   endtask

   task automatic cyc(input string tag, input logic v, input logic [3:0] op, input logic [15:0] p, input logic ov, input logic rr);
      exp_t e;
      i1.instr_valid = v; i1.opcode = op; i1.pc = p; i1.overflow = ov; i1.resume_req = rr;
      model_step(v, op, p, ov, rr);
      sb.push_back('{tag, model_out()});
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(), e.v);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      i1.instr_valid = 1'b0; i1.opcode = 4'h0; i1.pc = '0; i1.overflow = 1'b0; i1.resume_req = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_outputs", obs(), 32'h0);
      rst_n = 1'b1;
   endtask

   task automatic resume_out();
      cyc("halted_wait", 0, 4'h0, 16'h0, 0, 0);
      cyc("resume_enter", 0, 4'h0, 16'h0, 0, 1);
      cyc("resume_exit", 0, 4'h0, 16'h0, 0, 0);
   endtask

   initial begin
      do_reset();
      // 1: legal opcode stream, nothing happens
      for (int i = 0; i < 10; i++) cyc("legal_run", 1, 4'h4, 16'(i * 2), 0, 0);
      chk("legal_idle", {i1.stall, i1.flush, i1.halted, i1.cause, i1.exc_count}, 32'h0);
      // 2: illegal opcode
      cyc("ill_detect", 1, 4'h2, 16'h0040, 0, 0);
      chk("ill_flush1", {i1.flush, i1.halted, i1.stall}, 32'b101);
      cyc("ill_drain1", 1, 4'h4, 16'h0042, 0, 0);
      chk("ill_flush2", {i1.flush, i1.halted}, 32'b10);
      cyc("ill_drain2", 1, 4'h4, 16'h0044, 0, 0);
      chk("ill_halted", {i1.flush, i1.halted, i1.stall}, 32'b011);
      chk("ill_capture", {i1.cause, i1.epc, i1.exc_count}, {6'd0, 2'b01, 16'h0040, 8'd1});
      // 3: both causes, second fault during flush ignored
      do_reset();
      cyc("both_detect", 1, 4'h9, 16'h1234, 1, 0);
      cyc("flush_fault", 1, 4'h3, 16'h2222, 1, 1);
      cyc("flush_end", 0, 4'h0, 16'h0, 0, 0);
      chk("both_capture", {i1.cause, i1.epc, i1.exc_count, i1.halted}, {5'd0, 2'b11, 16'h1234, 8'd1, 1'b1});
      cyc("halt_fault", 1, 4'h7, 16'h3333, 0, 0);
      chk("halt_ignores", {i1.epc, i1.exc_count}, {8'd0, 16'h1234, 8'd1});
      // 4: resume with resume_req held for 3 clk
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         cyc("resume_hold", 0, 4'h0, 16'h0, 0, 1);
         acks += int'(i1.resume_ack);
         if (i == 0) chk("resume_state", {i1.resume_ack, i1.stall, i1.halted, i1.cause}, {27'd0, 1'b1, 1'b1, 1'b0, 2'b00});
         if (i == 1) chk("resume_run", {i1.stall, i1.epc}, {15'd0, 1'b0, 16'h1234});
      end
      chk("ack_once", 32'(acks), 32'd1);
      cyc("after_resume", 0, 4'h0, 16'h0, 0, 0);
      // exception and resume_req together in RUN: exception wins
      cyc("exc_with_rr", 1, 4'h1, 16'h0100, 0, 1);
      chk("exc_with_rr_taken", {i1.flush, i1.resume_ack, i1.epc}, {14'd0, 1'b1, 1'b0, 16'h0100});
      // 5: asynchronous reset during flush
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset", obs(), 32'h0);
      model_reset();
      #2;
      rst_n = 1'b1;
      cyc("post_reset_run", 0, 4'h0, 16'h0, 0, 0);
      cyc("post_reset_exc", 0, 4'h0, 16'h0, 1, 0);
      cyc("post_reset_exc2", 1, 4'hA, 16'h0500, 0, 0);
      chk("post_reset_flush", {i1.flush, i1.epc}, {15'd0, 1'b1, 16'h0500});
      // 6: masked instruction, then saturation of the 2-bit counter
      do_reset();
      cyc("masked", 0, 4'hE, 16'h0600, 1, 0);
      chk("masked_none", {i1.stall, i1.cause, i1.exc_count}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         cyc("sat_exc", 1, 4'hD, 16'(16'h0700 + k), 0, 0);
         cyc("sat_drain", 0, 4'h0, 16'h0, 0, 0);
         resume_out();
      end
      chk("sat_cnt2", 32'(i2.exc_count), 32'd3);
      chk("sat_cnt8", 32'(i1.exc_count), 32'd5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
